// File: rtl/scan_chain_ctrl_if.sv
// Bundle of request, response and serial-chain signals for scan_chain_ctrl.
// The slave modport is the controller's view; the master modport is the view
// of the surrounding test logic and flip-flop chain.
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 req_valid;
    logic                 req_ready;
    logic [CHAIN_LEN-1:0] req_data;
    logic                 scan_en;
    logic                 scan_out;
    logic                 scan_in;
    logic                 update;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [CHAIN_LEN-1:0] rsp_data;
    logic                 busy;
    logic                 parity_err;

    modport slave (
        input  req_valid, req_data, scan_in, rsp_ready,
        output req_ready, scan_en, scan_out, update, rsp_valid, rsp_data,
               busy, parity_err
    );

    modport master (
        output req_valid, req_data, scan_in, rsp_ready,
        input  req_ready, scan_en, scan_out, update, rsp_valid, rsp_data,
               busy, parity_err
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Serial scan chain sequencer: loads a word LSB-first into a D flip-flop chain
// while capturing the chain's previous contents, strobes update, then returns
// the captured word over a valid/ready response.
// Optional feature: define SCAN_CTRL_PARITY_EN to append an even-parity bit to
// each shifted word and check the parity bit captured back from the chain.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    scan_chain_ctrl_if.slave bus
);

`ifdef SCAN_CTRL_PARITY_EN
    localparam int STEPS = CHAIN_LEN + 1;
`else
    localparam int STEPS = CHAIN_LEN;
`endif
    localparam int CW = $clog2(CHAIN_LEN + 2);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        UPDATE,
        RESP
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [STEPS-1:0] r_shift;
    logic [STEPS-1:0] r_capture;
    logic [CW-1:0]    r_cnt;
    logic [STEPS-1:0] w_loadWord;
    logic             w_accept;
    logic             w_shiftDone;

    assign w_accept    = (r_state == IDLE) && bus.req_valid;
    assign w_shiftDone = (r_cnt == CW'(STEPS - 1));

`ifdef SCAN_CTRL_PARITY_EN
    assign w_loadWord = {^bus.req_data, bus.req_data};
`else
    assign w_loadWord = bus.req_data;
`endif

    // State register; reset always returns the sequencer to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state: one shift edge per chain flop, then a single update cycle
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_nextState = SHIFT;
            SHIFT:   if (w_shiftDone)   w_nextState = UPDATE;
            UPDATE:  w_nextState = RESP;
            RESP:    if (bus.rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Shift/capture datapath; the capture register keeps its word in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '0;
            r_capture <= '0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_shift <= w_loadWord;
            r_cnt   <= '0;
        end else if (r_state == SHIFT) begin
            r_shift <= r_shift >> 1;
            r_cnt   <= r_cnt + CW'(1);
            for (int i = 0; i < STEPS; i++) begin
                if (r_cnt == CW'(i)) begin
                    r_capture[i] <= bus.scan_in;
                end
            end
        end
    end

    // Outputs decoded from state; scan_out is forced low outside SHIFT
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.scan_en    = 1'b0;
        bus.scan_out   = 1'b0;
        bus.update     = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.busy       = 1'b1;
        bus.rsp_data   = r_capture[CHAIN_LEN-1:0];
        bus.parity_err = 1'b0;
        case (r_state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
            end
            SHIFT: begin
                bus.scan_en  = 1'b1;
                bus.scan_out = r_shift[0];
            end
            UPDATE: begin
                bus.update = 1'b1;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
`ifdef SCAN_CTRL_PARITY_EN
                bus.parity_err = r_capture[CHAIN_LEN] ^ (^r_capture[CHAIN_LEN-1:0]);
`endif
            end
            default: begin
                bus.busy = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Self-checking bench for scan_chain_ctrl with a behavioural flip-flop chain.
// The expected response is derived from a word-level model of what the chain
// holds, listed in the order the bits will emerge from its last flop.
module tb_scan_chain_ctrl;

    localparam int CL = 8;
`ifdef SCAN_CTRL_PARITY_EN
    localparam int N = CL + 1;
`else
    localparam int N = CL;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] chainReg = '0;
    logic         clearParityFlop = 1'b0;
    int           cycleCount = 0;
    int           totalChecks = 0;
    int           badChecks = 0;
    int           lastAccept = 0;
    logic [N-1:0] model = '0;

    scan_chain_ctrl_if #(.CHAIN_LEN(CL)) bus ();

    scan_chain_ctrl #(.CHAIN_LEN(CL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter for request-to-request period checks
    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural chain: flop 0 takes scan_out, last flop feeds scan_in
    always @(posedge clk) begin
        if (bus.scan_en) begin
            chainReg <= {chainReg[N-2:0], bus.scan_out};
        end else if (clearParityFlop) begin
            chainReg[0] <= 1'b0;
        end
    end

    assign bus.scan_in = chainReg[N-1];

    // Safety net so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_reqReady"}, 64'(bus.req_ready), 64'd1);
        checkOutput({tag, "_scanEn"}, 64'(bus.scan_en), 64'd0);
        checkOutput({tag, "_scanOut"}, 64'(bus.scan_out), 64'd0);
        checkOutput({tag, "_update"}, 64'(bus.update), 64'd0);
        checkOutput({tag, "_rspValid"}, 64'(bus.rsp_valid), 64'd0);
        checkOutput({tag, "_rspData"}, 64'(bus.rsp_data), 64'd0);
        checkOutput({tag, "_busy"}, 64'(bus.busy), 64'd0);
        checkOutput({tag, "_parityErr"}, 64'(bus.parity_err), 64'd0);
    endtask

    function automatic logic [N-1:0] fullWord(input logic [CL-1:0] word);
`ifdef SCAN_CTRL_PARITY_EN
        return {^word, word};
`else
        return word;
`endif
    endfunction

    // Drive a request and return at the negedge of the first shift cycle
    task automatic acceptRequest(input logic [CL-1:0] word, input bit rstOnAccept);
        int n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) checkOutput("readyTimeout", 64'd0, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_data  = word;
        if (rstOnAccept) begin
            rst = 1'b1;
            @(negedge clk);
            checkOutput("rstAccept_busy", 64'(bus.busy), 64'd0);
            checkOutput("rstAccept_reqReady", 64'(bus.req_ready), 64'd1);
            rst = 1'b0;
        end
        @(negedge clk);
        lastAccept    = cycleCount;
        bus.req_valid = 1'b0;
        bus.req_data  = CL'($urandom);
    endtask

    // Full transaction with rspDelay cycles of back-pressure in RESP
    task automatic applyStimulus(input logic [CL-1:0] word, input int rspDelay,
                                 input bit rstOnAccept);
        logic [N-1:0]  full;
        logic [CL-1:0] expRsp;
        logic          expErr;
        full   = fullWord(word);
        expRsp = model[CL-1:0];
`ifdef SCAN_CTRL_PARITY_EN
        expErr = model[CL] ^ (^model[CL-1:0]);
`else
        expErr = 1'b0;
`endif
        bus.rsp_ready = (rspDelay == 0);
        acceptRequest(word, rstOnAccept);
        for (int i = 0; i < N; i++) begin
            checkOutput("shift_scanEn", 64'(bus.scan_en), 64'd1);
            checkOutput("shift_scanOut", 64'(bus.scan_out), 64'(full >> i) & 64'd1);
            checkOutput("shift_reqReady", 64'(bus.req_ready), 64'd0);
            checkOutput("shift_update", 64'(bus.update), 64'd0);
            @(negedge clk);
        end
        checkOutput("upd_update", 64'(bus.update), 64'd1);
        checkOutput("upd_scanEn", 64'(bus.scan_en), 64'd0);
        checkOutput("upd_scanOut", 64'(bus.scan_out), 64'd0);
        checkOutput("upd_rspValid", 64'(bus.rsp_valid), 64'd0);
        @(negedge clk);
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rsp_data", 64'(bus.rsp_data), 64'(expRsp));
        checkOutput("rsp_parityErr", 64'(bus.parity_err), 64'(expErr));
        checkOutput("rsp_update", 64'(bus.update), 64'd0);
        for (int j = 0; j < rspDelay; j++) begin
            bus.req_valid = (j == 0);
            @(negedge clk);
            bus.req_valid = 1'b0;
            checkOutput("hold_rspValid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("hold_rspData", 64'(bus.rsp_data), 64'(expRsp));
            checkOutput("hold_reqReady", 64'(bus.req_ready), 64'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("done_rspValid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("done_reqReady", 64'(bus.req_ready), 64'd1);
        checkOutput("done_busy", 64'(bus.busy), 64'd0);
        checkOutput("done_parityErr", 64'(bus.parity_err), 64'd0);
        checkOutput("done_rspDataHeld", 64'(bus.rsp_data), 64'(expRsp));
        model = full;
    endtask

    // Transaction aborted by reset during shift cycle 3
    task automatic abortStimulus(input logic [CL-1:0] word);
        logic [N-1:0] full;
        int           p;
        full = fullWord(word);
        p    = 4;
        bus.rsp_ready = 1'b1;
        acceptRequest(word, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("abort_scanEn", 64'(bus.scan_en), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("abort");
        rst = 1'b0;
        model = (model >> p) | (full << (N - p));
    endtask

    initial begin
        int t1;
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b0;
        @(negedge clk);

        applyStimulus(8'hA5, 0, 1'b0);
        t1 = lastAccept;
        applyStimulus(8'h3C, 0, 1'b0);
        checkOutput("period_3C", 64'(lastAccept - t1), 64'(N + 3));
        applyStimulus(CL'($urandom), 5, 1'b0);
        abortStimulus(CL'($urandom));
        applyStimulus(8'hFF, 0, 1'b0);
        t1 = lastAccept;
        applyStimulus(CL'($urandom), 0, 1'b0);
        checkOutput("period_afterFF", 64'(lastAccept - t1), 64'(N + 3));
        applyStimulus(CL'($urandom), 0, 1'b1);

`ifdef SCAN_CTRL_PARITY_EN
        applyStimulus(8'h01, 0, 1'b0);
        applyStimulus(8'h01, 0, 1'b0);
        clearParityFlop = 1'b1;
        @(negedge clk);
        clearParityFlop = 1'b0;
        model[N-1] = 1'b0;
        applyStimulus(8'h01, 0, 1'b0);
        applyStimulus(CL'($urandom), 0, 1'b0);
`endif

        for (int k = 0; k < 20; k++) begin
            applyStimulus(CL'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
